ex_stage_pipe: RTL
==================

// Module: ex_stage_pipe
// PURPOSE
//  Parametrised execute stage with a registered EX/MEM output. Sits between the ID/EX register and
//  the MEM stage and replaces the fixed 32-bit EX path.
//  - Adds operand forwarding from MEM and WB.
//  - Adds a valid/ready handshake with downstream stall and flush.
//  - Adds an optional iterative multi-cycle multiplier.
// PARAMETERS
//  DATA_W   32  datapath width (ALU operands, PC, results)
//  ADDR_W    5  register-address width
// PORTS
//  Clk             in   1       clock, all state on rising edge
//  Rst_n           in   1       asynchronous, active-low reset
//  In_Valid        in   1       ID/EX supplies a valid instruction this cycle
//  In_Ready        out  1       stage accepts the instruction this cycle
//  Flush           in   1       kill the in-flight instruction (branch taken)
//  Stall_In        in   1       downstream cannot accept; hold outputs
//  PC_IN           in   DATA_W  PC+4 of the instruction
//  RD1_IN, RD2_IN  in   DATA_W  register-file read data
//  Imm_IN          in   DATA_W  sign-extended immediate; Imm_IN[5:0] is the funct field
//  RS_IN, RT_IN    in   ADDR_W  source register numbers
//  WR1_IN, WR2_IN  in   ADDR_W  rt / rd destination candidates
//  WB_IN           in   2       WB control, passed through
//  MEM_IN          in   3       MEM control, passed through
//  EX_IN           in   4       [3] RegDst, [2:1] AluOp, [0] AluSrc
//  MEM_FwdWrite, MEM_FwdReg, MEM_FwdData   in  1/ADDR_W/DATA_W  MEM-stage forward source
//  WB_FwdWrite,  WB_FwdReg,  WB_FwdData    in  1/ADDR_W/DATA_W  WB-stage forward source
//  Out_Valid       out  1       EX/MEM register holds a valid instruction
//  WB_OUT, MEM_OUT out  2/3     registered control
//  BranchPC_OUT    out  DATA_W  PC_IN + (Imm_IN<<2), modulo 2^DATA_W
//  Zero_OUT        out  1       AluResult == 0
//  AluResult_OUT   out  DATA_W  ALU or multiplier result
//  RD2_OUT         out  DATA_W  forwarded rt value (store data)
//  WR_OUT          out  ADDR_W  RegDst ? WR2_IN : WR1_IN
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, multiplier accumulator 0, In_Ready=1.
//  - Forwarding: per operand, MEM source beats WB source beats RDx_IN. A source matches only if
//    FwdWrite=1, FwdReg==RS/RT and FwdReg!=0. RD2_OUT carries the forwarded rt value.
//  - ALU operand B: AluSrc ? Imm_IN : forwarded rt.
//  - AluOp decode:
//    - 00 = add; 01 = sub; 11 = or.
//    - 10 = funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (0/1),
//      0x18 mul (low DATA_W bits); any other funct -> 0.
//    - Arithmetic wraps modulo 2^DATA_W.
//  - FSM states:
//    - IDLE: In_Ready = !Stall_In.
//      - Accept when In_Valid && In_Ready.
//      - Single-cycle op: registered next edge, latency 1.
//      - mul: latch operands, go to MUL_BUSY, Out_Valid=0 next edge.
//    - MUL_BUSY: In_Ready=0; shift-add one bit/cycle for DATA_W cycles.
//      - On the last cycle with !Stall_In: write all outputs, Out_Valid=1, go to IDLE.
//      - Total mul latency DATA_W+1 edges from accept.
//      - If Stall_In is high on the last cycle, remain in MUL_BUSY holding the result until it drops.
//  - Stall_In=1: EX/MEM register holds all fields; no accept; the multiplier keeps iterating.
//  - Not accepted and no Stall_In (bubble): Out_Valid=0, WB_OUT=0, MEM_OUT=0; data fields don't care.
//  - Flush=1:
//    - Next edge Out_Valid=0, WB_OUT=0, MEM_OUT=0; aborts MUL_BUSY to IDLE.
//    - An instruction offered in the same cycle is dropped.
//  - Priority: Rst_n > Flush > Stall_In > accept.
//  - Reset mid-mul: immediate abort, outputs 0.
// CONFIGURATION
//  EX_MUL_EN defined: multiplier, MUL_BUSY state and funct 0x18 are present.
//  EX_MUL_EN undefined:
//    - funct 0x18 decodes as "other" (result 0), single-cycle, never busy.
//    - FSM reduces to IDLE.
// TESTING
//  1 add, DATA_W=32: RD1=5, RD2=7, funct 0x20, no fwd -> 1 edge later AluResult=12, Zero=0, Out_Valid=1.
//  2 Forwarding: RS=3, MEM_Fwd(1,3,100), WB_Fwd(1,3,50), RD1=1, Imm=2, AluSrc=1, AluOp=00
//    -> AluResult=102. Repeat with RS=0 -> 3.
//  3 Branch: PC_IN=0x100, Imm=0xFFFFFFFF, sub 4-4 -> BranchPC=0xFC, Zero=1.
//    DATA_W=16: 0xFFFF+1 -> AluResult=0.
//  4 mul (EX_MUL_EN): 6*7 -> In_Ready=0 for 32 cycles, Out_Valid=1 with 42 at edge 33.
//    Without EX_MUL_EN -> 0 after 1 edge.
//  5 Stall_In high 3 cycles after a valid result -> outputs held, In_Ready=0.
//    Release -> next instruction captured.
//  6 Flush during MUL_BUSY and Rst_n low mid-op -> Out_Valid=0, WB/MEM=0, In_Ready=1 next cycle.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// Execute stage with a registered EX/MEM output.
// Forwards operands from MEM and WB, handshakes on valid/ready with downstream
// stall and flush. The iterative shift-add multiplier (funct 0x18) is present
// only when EX_MUL_EN is defined.
module ex_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Flush,
  input  logic              Stall_In,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic [DATA_W-1:0] RD1_IN,
  input  logic [DATA_W-1:0] RD2_IN,
  input  logic [DATA_W-1:0] Imm_IN,
  input  logic [ADDR_W-1:0] RS_IN,
  input  logic [ADDR_W-1:0] RT_IN,
  input  logic [ADDR_W-1:0] WR1_IN,
  input  logic [ADDR_W-1:0] WR2_IN,
  input  logic [1:0]        WB_IN,
  input  logic [2:0]        MEM_IN,
  input  logic [3:0]        EX_IN,
  input  logic              MEM_FwdWrite,
  input  logic [ADDR_W-1:0] MEM_FwdReg,
  input  logic [DATA_W-1:0] MEM_FwdData,
  input  logic              WB_FwdWrite,
  input  logic [ADDR_W-1:0] WB_FwdReg,
  input  logic [DATA_W-1:0] WB_FwdData,
  output logic              Out_Valid,
  output logic [1:0]        WB_OUT,
  output logic [2:0]        MEM_OUT,
  output logic [DATA_W-1:0] BranchPC_OUT,
  output logic              Zero_OUT,
  output logic [DATA_W-1:0] AluResult_OUT,
  output logic [DATA_W-1:0] RD2_OUT,
  output logic [ADDR_W-1:0] WR_OUT
);

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state;

  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_res, branch_pc;
  logic [ADDR_W-1:0] wr_sel;
  logic [5:0]        funct;
  logic              accept;

  assign funct     = Imm_IN[5:0];
  assign op_b      = EX_IN[0] ? Imm_IN : fwd_b;
  assign branch_pc = PC_IN + (Imm_IN << 2);
  assign wr_sel    = EX_IN[3] ? WR2_IN : WR1_IN;
  assign In_Ready  = (state == IDLE) && !Stall_In;
  // A flush kills whatever is offered in the same cycle.
  assign accept    = In_Valid && In_Ready && !Flush;

  // Operand forwarding: MEM beats WB beats register file; r0 never forwards.
  always_comb begin
    fwd_a = RD1_IN;
    if (MEM_FwdWrite && MEM_FwdReg == RS_IN && RS_IN != '0)   fwd_a = MEM_FwdData;
    else if (WB_FwdWrite && WB_FwdReg == RS_IN && RS_IN != '0) fwd_a = WB_FwdData;
    fwd_b = RD2_IN;
    if (MEM_FwdWrite && MEM_FwdReg == RT_IN && RT_IN != '0)   fwd_b = MEM_FwdData;
    else if (WB_FwdWrite && WB_FwdReg == RT_IN && RT_IN != '0) fwd_b = WB_FwdData;
  end

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic              is_mul, mul_last;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pend_pc, pend_rd2;
  logic [ADDR_W-1:0] pend_wr;
  logic [1:0]        pend_wb;
  logic [2:0]        pend_mem;

  // Once all multiplier bits are shifted out acc_next == acc, so a stalled
  // final cycle keeps presenting the finished product.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = cnt >= CNT_W'(DATA_W - 1);
`endif

  // ALU decode; the multiply result comes from the iterative unit instead.
  always_comb begin
    alu_res = '0;
`ifdef EX_MUL_EN
    is_mul  = 1'b0;
`endif
    case (EX_IN[2:1])
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      2'b11: alu_res = fwd_a | op_b;
      default: begin
        case (funct)
          6'h20: alu_res = fwd_a + op_b;
          6'h22: alu_res = fwd_a - op_b;
          6'h24: alu_res = fwd_a & op_b;
          6'h25: alu_res = fwd_a | op_b;
          6'h2A: alu_res = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
`ifdef EX_MUL_EN
          6'h18: is_mul  = 1'b1;
`endif
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // FSM, multiplier iteration and the EX/MEM register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      Out_Valid     <= 1'b0;
      WB_OUT        <= '0;
      MEM_OUT       <= '0;
      BranchPC_OUT  <= '0;
      Zero_OUT      <= 1'b0;
      AluResult_OUT <= '0;
      RD2_OUT       <= '0;
      WR_OUT        <= '0;
`ifdef EX_MUL_EN
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      pend_pc  <= '0;
      pend_rd2 <= '0;
      pend_wr  <= '0;
      pend_wb  <= '0;
      pend_mem <= '0;
`endif
    end else if (Flush) begin
      state     <= IDLE;
      Out_Valid <= 1'b0;
      WB_OUT    <= '0;
      MEM_OUT   <= '0;
    end else begin
`ifdef EX_MUL_EN
      if (state == MUL_BUSY) begin
        // Keeps iterating under stall; output only moves when not stalled.
        if (cnt != CNT_W'(DATA_W)) begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        if (!Stall_In) begin
          if (mul_last) begin
            state         <= IDLE;
            Out_Valid     <= 1'b1;
            WB_OUT        <= pend_wb;
            MEM_OUT       <= pend_mem;
            BranchPC_OUT  <= pend_pc;
            AluResult_OUT <= acc_next;
            Zero_OUT      <= (acc_next == '0);
            RD2_OUT       <= pend_rd2;
            WR_OUT        <= pend_wr;
          end else begin
            Out_Valid <= 1'b0;
            WB_OUT    <= '0;
            MEM_OUT   <= '0;
          end
        end
      end else
`endif
      if (!Stall_In) begin
        if (!accept) begin
          Out_Valid <= 1'b0;
          WB_OUT    <= '0;
          MEM_OUT   <= '0;
        end
`ifdef EX_MUL_EN
        else if (is_mul) begin
          state     <= MUL_BUSY;
          Out_Valid <= 1'b0;
          WB_OUT    <= '0;
          MEM_OUT   <= '0;
          mcand     <= fwd_a;
          mplier    <= op_b;
          acc       <= '0;
          cnt       <= '0;
          pend_pc   <= branch_pc;
          pend_rd2  <= fwd_b;
          pend_wr   <= wr_sel;
          pend_wb   <= WB_IN;
          pend_mem  <= MEM_IN;
        end
`endif
        else begin
          Out_Valid     <= 1'b1;
          WB_OUT        <= WB_IN;
          MEM_OUT       <= MEM_IN;
          BranchPC_OUT  <= branch_pc;
          AluResult_OUT <= alu_res;
          Zero_OUT      <= (alu_res == '0);
          RD2_OUT       <= fwd_b;
          WR_OUT        <= wr_sel;
        end
      end
    end
  end

endmodule
